// File: rtl/hw_accel_pkg.sv
// hw_accel shared definitions: colour mode encodings and
// the frame FSM state encoding used by the stream blocks.
package hw_accel_pkg;

    localparam logic [1:0] MODE_REPL = 2'd0;
    localparam logic [1:0] MODE_JET  = 2'd1;
    localparam logic [1:0] MODE_INV  = 2'd2;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/hw_accel_gray2rgb_map_1PPC.sv
// Combinational per-pixel gray to RGB mapper:
// replicate, inverted replicate or 4-segment jet colour.
module hw_accel_gray2rgb_map_1PPC
    import hw_accel_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] gray,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] r,
    output logic [DATA_WIDTH-1:0] g,
    output logic [DATA_WIDTH-1:0] b
);

    localparam logic [DATA_WIDTH-1:0] MAX = {DATA_WIDTH{1'b1}};

    logic [1:0]            seg;
    logic [DATA_WIDTH-1:0] up;

    // top two bits pick the segment, the rest ramp within it
    assign seg = gray[DATA_WIDTH-1 -: 2];
    assign up  = {gray[DATA_WIDTH-3:0], 2'b00};

    always_comb begin
        r = gray;
        g = gray;
        b = gray;
        unique case (1'b1)
            (mode == MODE_INV): begin
                r = MAX - gray;
                g = MAX - gray;
                b = MAX - gray;
            end
            (mode == MODE_JET): begin
                case (seg)
                    2'd0: begin
                        r = '0;
                        g = up;
                        b = MAX;
                    end
                    2'd1: begin
                        r = '0;
                        g = MAX;
                        b = MAX - up;
                    end
                    2'd2: begin
                        r = up;
                        g = MAX;
                        b = '0;
                    end
                    default: begin
                        r = MAX;
                        g = MAX - up;
                        b = '0;
                    end
                endcase
            end
            default: begin
                r = gray;
                g = gray;
                b = gray;
            end
        endcase
    end

endmodule

// File: rtl/hw_accel_gray2rgb_stream.sv
// Streaming gray to RGB expander, PPC pixels per beat,
// 2-stage valid/ready pipeline with per-frame mode lock.
module hw_accel_gray2rgb_stream
    import hw_accel_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PPC        = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PPC*DATA_WIDTH-1:0] in_gray,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PPC*DATA_WIDTH-1:0] out_red,
    output logic [PPC*DATA_WIDTH-1:0] out_green,
    output logic [PPC*DATA_WIDTH-1:0] out_blue,
    output logic                      out_last
);

    localparam int W = PPC * DATA_WIDTH;

    logic [0:0] state;
    logic [1:0] mode_q;
    logic [1:0] eff_mode;
    logic       acc;

    logic         s1_valid;
    logic         s1_last;
    logic [W-1:0] s1_gray;
    logic [1:0]   s1_mode;
    logic         s2_valid;
    logic         s2_en;

    logic [W-1:0] map_r;
    logic [W-1:0] map_g;
    logic [W-1:0] map_b;

    assign in_ready  = !s1_valid || !s2_valid || out_ready;
    assign acc       = in_valid && in_ready;
    assign s2_en     = s1_valid && (!s2_valid || out_ready);
    assign out_valid = s2_valid;

    // the first beat of a frame uses the live mode, later beats the locked one
    assign eff_mode = (state == ST_IDLE) ? mode : mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            mode_q <= MODE_REPL;
        end else if (acc) begin
            if (state == ST_IDLE) begin
                mode_q <= mode;
                state  <= in_last ? ST_IDLE : ST_ACTIVE;
            end else if (in_last) begin
                state <= ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_gray  <= '0;
            s1_mode  <= MODE_REPL;
        end else if (acc) begin
            s1_valid <= 1'b1;
            s1_last  <= in_last;
            s1_gray  <= in_gray;
            s1_mode  <= eff_mode;
        end else if (s2_en) begin
            s1_valid <= 1'b0;
        end
    end

    for (genvar i = 0; i < PPC; i++) begin : g_px
        hw_accel_gray2rgb_map_1PPC #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_map (
            .gray(s1_gray[i*DATA_WIDTH +: DATA_WIDTH]),
            .mode(s1_mode),
            .r   (map_r[i*DATA_WIDTH +: DATA_WIDTH]),
            .g   (map_g[i*DATA_WIDTH +: DATA_WIDTH]),
            .b   (map_b[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            out_last  <= 1'b0;
            out_red   <= '0;
            out_green <= '0;
            out_blue  <= '0;
        end else if (s2_en) begin
            s2_valid  <= 1'b1;
            out_last  <= s1_last;
            out_red   <= map_r;
            out_green <= map_g;
            out_blue  <= map_b;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

endmodule

// File: doc/hw_accel_gray2rgb_stream.md
Name: hw_accel_gray2rgb_stream

Overview:
Streaming gray-to-RGB expander. It is the inverse-direction companion of the RGB-to-gray converter and sits in the hw_accel path between the grayscale/inference-visualisation stage and the RGB display/framebuffer writer. It accepts PPC gray pixels per beat over a valid/ready stream and emits PPC RGB pixels per beat through a 2-stage registered pipeline. Three colour modes are supported: replicate, inverted replicate and 4-segment "jet" pseudo-colour. The mode is locked per frame.

Parameters:
DATA_WIDTH, 8, bits per colour component and per gray pixel (legal values 4..16).
PPC, 2, pixels per clock (beat).

Ports:
clk  in  1  system clock.
rst  in  1  reset, synchronous, active-high.
mode  in  2  colour mode: 0 = replicate, 1 = jet, 2 = invert, 3 = reserved (behaves as 0).
in_valid  in  1  input beat valid.
in_ready  out  1  input beat accepted when in_valid && in_ready.
in_gray  in  PPC*DATA_WIDTH  gray pixels; pixel i occupies [(i+1)*DW-1 : i*DW].
in_last  in  1  last beat of frame.
out_valid  out  1  output beat valid.
out_ready  in  1  downstream accept.
out_red  out  PPC*DATA_WIDTH  red components, same lane packing as in_gray.
out_green  out  PPC*DATA_WIDTH  green components.
out_blue  out  PPC*DATA_WIDTH  blue components.
out_last  out  1  in_last delayed with its beat.

Behaviour:
Reset:
- Clears s1_valid, s2_valid, out_valid, out_last and all out_* data to 0.
- FSM goes to IDLE; mode_q = 0.
- Reset asserted mid-frame discards all in-flight beats; no partial output follows.
- in_ready = 1 in the cycle after reset deasserts.

Frame FSM, two states:
- IDLE: the first accepted beat captures mode into mode_q; that beat and all later beats of the frame use the captured mode. Next state is ACTIVE. If the first beat also has in_last = 1, the state stays IDLE.
- ACTIVE: mode_q is held and mode input changes are ignored. An accepted beat with in_last = 1 returns the FSM to IDLE.

Pipeline:
- Stage 1 registers gray, last and the effective mode.
- Stage 2 registers the mapped R/G/B and last; stage 2 drives the outputs directly.
- in_ready = !s1_valid || !s2_valid || out_ready. This is combinational from out_ready, and bubbles collapse.
- A stage advances when its downstream is empty or being consumed.
- Latency is 2 cycles from acceptance to out_valid when out_ready is held high. Throughput is 1 beat/cycle.
- While out_valid && !out_ready, all out_* are held stable. No beat is dropped or duplicated. A full pipeline with stalled output gives in_ready = 0.
- Simultaneous input accept and output consume in the same cycle when full: both occur, and occupancy stays at 2.

Per-pixel mapping (MAX = 2^DW-1):
- replicate: R = G = B = g.
- invert: R = G = B = MAX - g.
- jet:
  - seg = g[DW-1:DW-2], f = g[DW-3:0], up = {f, 2'b00} (DW bits).
  - seg0: (0, up, MAX).
  - seg1: (0, MAX, MAX-up).
  - seg2: (up, MAX, 0).
  - seg3: (MAX, MAX-up, 0).
- All arithmetic is unsigned DW bits. No overflow is possible by construction.

Decomposition:
- Shared package hw_accel_pkg holds: mode encodings MODE_REPL = 2'd0, MODE_JET = 2'd1, MODE_INV = 2'd2, and the FSM state encoding (IDLE/ACTIVE).
- Sub-module hw_accel_gray2rgb_map_1PPC is the purely combinational per-pixel mapper (inputs gray and mode, outputs r/g/b). It is instantiated PPC times in a generate loop and feeds the stage-2 registers.

Test Plan:
- Replicate, DW = 8, PPC = 2, out_ready = 1. Send beat {0x80, 0x12} -> two cycles later out_valid = 1 with R = G = B = {0x80, 0x12}.
- Jet mode on gray 0, 64, 128, 255 -> (0,0,255), (0,255,255), (0,255,0), (255,3,0) in order.
- Mode lock. Start a frame in mode 2, switch mode to 1 mid-frame -> the remaining beats are still inverted (g = 0x10 -> 0xEF). After the in_last beat, the next frame uses jet.
- Backpressure:
  - Random in_valid/out_ready over 1000 beats -> the output sequence equals the model exactly, with no loss or duplication.
  - Output data stays stable during stalls.
  - in_ready is 0 only when both stages are full and out_ready = 0.
- Reset with 2 beats in flight -> next cycle out_valid = 0 and outputs are 0. No stale beats appear afterwards, and the FSM returns to IDLE (the next frame recaptures mode).
- Reserved mode 3 with g = 0x5A -> R = G = B = 0x5A. Single-beat frame (in_last on first beat) -> FSM remains IDLE, and out_last is asserted with that beat.
